// File: rtl/connect4_pkg.sv
// Shared Connect-4 board geometry, DetectWinner status encodings and move
// controller FSM states.
package connect4_pkg;

  localparam int ROWS       = 4;
  localparam int COLS       = 4;
  localparam int CELLS      = ROWS * COLS;
  localparam int CELL_W     = $clog2(CELLS);
  localparam int COL_W      = $clog2(COLS);
  localparam int COUNT_W    = $clog2(CELLS + 1);
  localparam int DETECT_LAT = 1;

  localparam logic [1:0] ST_PLAYING = 2'b00;
  localparam logic [1:0] ST_P1_WIN  = 2'b01;
  localparam logic [1:0] ST_P2_WIN  = 2'b10;
  localparam logic [1:0] ST_TIE     = 2'b11;

  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

  typedef enum logic [1:0] {
    WAIT_MOVE,
    CHECK,
    GAME_OVER
  } state_t;

endpackage

// File: rtl/c4_drop_locator.sv
// Gravity lookup: reports whether a column is full and, if not, the lowest
// empty cell in it. Out-of-range columns report full.
module c4_drop_locator
  import connect4_pkg::*;
(
  input  logic [CELLS-1:0]  game_board,
  input  logic [COL_W-1:0]  column,
  output logic              col_full,
  output logic [CELL_W-1:0] target
);

  // NOTE: every output gets a default before the loops, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    col_full = 1'b1;
    target   = '0;
    for (int c = 0; c < COLS; c++) begin
      if (column == COL_W'(c)) begin
        col_full = game_board[(ROWS-1)*COLS + c];
        // Scan top-down so the last hit is the lowest empty row.
        for (int r = ROWS - 1; r >= 0; r--) begin
          if (!game_board[r*COLS + c]) target = CELL_W'(r*COLS + c);
        end
      end
    end
  end

endmodule

// File: rtl/c4_move_controller.sv
// Owns the Connect-4 board, accepts column drops, alternates turns and
// latches the DetectWinner verdict after each placement.
module c4_move_controller
  import connect4_pkg::*;
#(
  parameter int DETECT_LAT_P = DETECT_LAT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               new_game,
  input  logic               move_valid,
  input  logic [COL_W-1:0]   move_col,
  output logic               move_ready,
  output logic               move_ack,
  output logic               move_err,
  output logic [CELLS-1:0]   game_board,
  output logic [CELLS-1:0]   player_cells,
  output logic               current_player,
  output logic [COUNT_W-1:0] move_count,
  input  logic [1:0]         game_status,
  output logic [1:0]         final_status,
  output logic               game_over
);

  localparam int WAIT_W = (DETECT_LAT_P > 1) ? $clog2(DETECT_LAT_P + 1) : 1;

  state_t               state_q, state_d;
  logic [CELLS-1:0]     board_q, board_d;
  logic [CELLS-1:0]     owner_q, owner_d;
  logic                 player_q, player_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [1:0]           final_q, final_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;

  logic                 col_full;
  logic [CELL_W-1:0]    target;

  c4_drop_locator u_drop_locator (
    .game_board (board_q),
    .column     (move_col),
    .col_full   (col_full),
    .target     (target)
  );

  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    owner_d  = owner_q;
    player_d = player_q;
    count_d  = count_q;
    final_d  = final_q;
    wait_d   = wait_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;

    if (new_game) begin
      state_d  = WAIT_MOVE;
      board_d  = '0;
      owner_d  = '0;
      player_d = P1;
      count_d  = '0;
      final_d  = ST_PLAYING;
      wait_d   = '0;
    end else begin
      unique case (state_q)
        WAIT_MOVE: begin
          if (move_valid) begin
            if (col_full) begin
              err_d = 1'b1;
            end else begin
              board_d[target] = 1'b1;
              owner_d[target] = player_q;
              count_d         = count_q + COUNT_W'(1);
              ack_d           = 1'b1;
              wait_d          = WAIT_W'(DETECT_LAT_P);
              state_d         = CHECK;
            end
          end
        end
        CHECK: begin
          if (wait_q != '0) begin
            wait_d = wait_q - WAIT_W'(1);
          end else begin
            unique case (game_status)
              ST_P1_WIN, ST_P2_WIN, ST_TIE: begin
                final_d = game_status;
                state_d = GAME_OVER;
              end
              ST_PLAYING: begin
                // A full board without a reported winner is still a tie.
                if (count_q == COUNT_W'(CELLS)) begin
                  final_d = ST_TIE;
                  state_d = GAME_OVER;
                end else begin
                  player_d = (player_q == P1) ? P2 : P1;
                  state_d  = WAIT_MOVE;
                end
              end
            endcase
          end
        end
        GAME_OVER: ;
        default: state_d = WAIT_MOVE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= WAIT_MOVE;
      board_q  <= '0;
      owner_q  <= '0;
      player_q <= P1;
      count_q  <= '0;
      final_q  <= ST_PLAYING;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      owner_q  <= owner_d;
      player_q <= player_d;
      count_q  <= count_d;
      final_q  <= final_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      wait_q   <= wait_d;
    end
  end

  assign move_ready     = (state_q == WAIT_MOVE);
  assign game_over      = (state_q == GAME_OVER);
  assign move_ack       = ack_q;
  assign move_err       = err_q;
  assign game_board     = board_q;
  assign player_cells   = owner_q;
  assign current_player = player_q;
  assign move_count     = count_q;
  assign final_status   = final_q;

endmodule
